// File: rtl/rr_grant_ctrl_pkg.sv
// Shared defaults and state encoding for the round-robin grant controller.
package arb_pkg;
    localparam int N_DEF        = 8;
    localparam int IDX_W_DEF    = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic {ST_IDLE, ST_GRANT} state_e;
endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_grant_ctrl_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
);
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             err_timeout;

    modport master (output req, done, input gnt, gnt_idx, gnt_vld, err_timeout);
    modport slave  (input req, done, output gnt, gnt_idx, gnt_vld, err_timeout);
endinterface

// File: rtl/rr_grant_ctrl_onehot_to_bin.sv
// One-hot to binary encoder; an all-zero input encodes to 0.
module onehot_to_bin #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     oh,
    output logic [IDX_W-1:0] idx
);
    // OR of the set positions: exact for one-hot, 0 for zero input
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++)
            if (oh[i]) idx = idx | IDX_W'(i);
    end
endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter: rotating priority, registered one-hot grant held until
// done or the hold limit, with a one-cycle pulse on forced release.
module rr_grant_ctrl
    import arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input logic            clk,
    input logic            rst,
    rr_grant_ctrl_if.slave bus
);
    localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    state_e           state;
    logic [N-1:0]     gnt_q;
    logic             vld_q;
    logic             err_q;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] nxt_ptr;
    logic [HC_W-1:0]  hold_cnt;
    logic [N-1:0]     pick_cur;
    logic [N-1:0]     pick_nxt;
    logic             at_limit;
    logic             release_g;

    // First set request scanning base, base+1, ... with wrap
    function automatic logic [N-1:0] pick(input logic [N-1:0] r, input logic [IDX_W-1:0] base);
        logic [N-1:0] oh;
        logic         found;
        int           j;
        oh    = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(base) + i) % N;
            if (!found && r[j]) begin
                oh[j] = 1'b1;
                found = 1'b1;
            end
        end
        return oh;
    endfunction

    onehot_to_bin #(.N(N), .IDX_W(IDX_W)) u_enc (.oh(gnt_q), .idx(idx));

    assign nxt_ptr   = (idx == IDX_W'(N - 1)) ? '0 : idx + 1'b1;
    assign pick_cur  = pick(bus.req, ptr);
    assign pick_nxt  = pick(bus.req, nxt_ptr);
    assign at_limit  = (MAX_HOLD != 0) && (hold_cnt == HC_W'(MAX_HOLD - 1));
    assign release_g = bus.done || at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt_q    <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        state    <= ST_GRANT;
                        gnt_q    <= pick_cur;
                        vld_q    <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_g) begin
                        // done on the limit edge counts as a normal release
                        err_q    <= at_limit && !bus.done;
                        ptr      <= nxt_ptr;
                        hold_cnt <= '0;
                        if (|bus.req) begin
                            gnt_q <= pick_nxt;
                        end else begin
                            state <= ST_IDLE;
                            gnt_q <= '0;
                            vld_q <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt_q <= '0;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.gnt_idx     = idx;
    assign bus.gnt_vld     = vld_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed scenarios plus random traffic against a holder/visible-cycles model.
module tb_rr_grant_ctrl;
    localparam int N        = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    // reference model: who holds, how many cycles it has been visible, pointer
    int   m_holder = -1;
    int   m_seen   = 0;
    int   m_ptr    = 0;
    logic m_err    = 1'b0;

    rr_grant_ctrl_if #(.N(N), .IDX_W(IDX_W)) bus ();

    rr_grant_ctrl #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int base);
        for (int i = 0; i < N; i++)
            if (r[(base + i) % N]) return (base + i) % N;
        return -1;
    endfunction

    task automatic model_edge();
        logic limit;
        m_err = 1'b0;
        if (rst) begin
            m_holder = -1; m_seen = 0; m_ptr = 0;
        end else if (m_holder < 0) begin
            m_holder = rr_pick(bus.req, m_ptr);
            m_seen   = (m_holder < 0) ? 0 : 1;
        end else begin
            limit = (MAX_HOLD != 0) && (m_seen == MAX_HOLD);
            if (bus.done || limit) begin
                m_err    = limit && !bus.done;
                m_ptr    = (m_holder + 1) % N;
                m_holder = rr_pick(bus.req, m_ptr);
                m_seen   = (m_holder < 0) ? 0 : 1;
            end else begin
                m_seen++;
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] q, input logic d);
        logic [N-1:0] eg;
        rst      = r;
        bus.req  = q;
        bus.done = d;
        @(posedge clk);
        model_edge();
        #1;
        eg = (m_holder < 0) ? '0 : (N'(1) << m_holder);
        chk("gnt",     32'(bus.gnt),         32'(eg));
        chk("gnt_idx", 32'(bus.gnt_idx),     (m_holder < 0) ? 32'd0 : 32'(m_holder));
        chk("gnt_vld", 32'(bus.gnt_vld),     32'(m_holder >= 0));
        chk("err",     32'(bus.err_timeout), 32'(m_err));
    endtask

    initial begin
        logic [N-1:0] rq;
        bus.req  = '0;
        bus.done = 1'b0;

        // reset with all requests asserted
        step(1, 8'hFF, 0);
        step(1, 8'hFF, 0);
        chk("t1_gnt", 32'(bus.gnt), 32'h0);
        chk("t1_vld", 32'(bus.gnt_vld), 32'h0);

        // single requester, released by done, pointer moves to 6
        step(0, 8'h20, 0);
        chk("t2_gnt", 32'(bus.gnt), 32'h20);
        chk("t2_idx", 32'(bus.gnt_idx), 32'd5);
        step(0, 8'h20, 0);
        step(0, 8'h00, 0);
        chk("t2_hold", 32'(bus.gnt), 32'h20);
        step(0, 8'h00, 1);
        chk("t2_rel", 32'(bus.gnt), 32'h0);
        step(0, 8'h41, 0);
        chk("t2_ptr6", 32'(bus.gnt_idx), 32'd6);
        step(0, 8'h00, 1);

        // fairness: back-to-back rotation from ptr 0
        step(1, 8'h00, 0);
        step(0, 8'hFF, 1);
        chk("t3_first", 32'(bus.gnt_idx), 32'd0);
        for (int i = 1; i < 10; i++) begin
            step(0, 8'hFF, 1);
            chk("t3_seq", 32'(bus.gnt_idx), 32'(i % N));
            chk("t3_nogap", 32'(bus.gnt_vld), 32'd1);
        end
        step(0, 8'h00, 1);

        // wrap: after grant 6 the pointer is 7, so 0 beats 1
        step(1, 8'h00, 0);
        step(0, 8'h40, 0);
        step(0, 8'h03, 1);
        chk("t4_wrap0", 32'(bus.gnt_idx), 32'd0);
        step(0, 8'h03, 1);
        chk("t4_then1", 32'(bus.gnt_idx), 32'd1);
        step(0, 8'h00, 1);

        // timeout: visible exactly MAX_HOLD cycles, then one error pulse
        step(1, 8'h00, 0);
        for (int i = 0; i < MAX_HOLD; i++) begin
            step(0, (i == MAX_HOLD - 1) ? 8'h00 : 8'h04, 0);
            chk("t5_held", 32'(bus.gnt), 32'h04);
        end
        step(0, 8'h00, 0);
        chk("t5_err", 32'(bus.err_timeout), 32'd1);
        chk("t5_drop", 32'(bus.gnt), 32'h0);
        step(0, 8'h0C, 0);
        chk("t5_pulse", 32'(bus.err_timeout), 32'd0);
        chk("t5_ptr3", 32'(bus.gnt_idx), 32'd3);
        // done on the limit edge: normal release
        step(1, 8'h00, 0);
        for (int i = 0; i < MAX_HOLD; i++) step(0, 8'h04, 0);
        step(0, 8'h00, 1);
        chk("t5_noerr", 32'(bus.err_timeout), 32'd0);

        // reset mid-grant
        step(1, 8'h00, 0);
        step(0, 8'h08, 0);
        chk("t6_gnt", 32'(bus.gnt), 32'h08);
        step(1, 8'h08, 0);
        chk("t6_rst", 32'(bus.gnt_vld), 32'd0);
        step(0, 8'h09, 0);
        chk("t6_idx", 32'(bus.gnt_idx), 32'd0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rq = N'($urandom);
            if ($urandom_range(0, 3) == 0) rq = '0;
            step($urandom_range(0, 99) == 0, rq, $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
